// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and constants for the fetch stage
// Provides XLEN, the PC increment, the default bubble word, the fetch FSM state
// enum, and helpers for branch-target alignment and saturating counting.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] NOP_BUBBLE = 32'h0000_0000;
    typedef enum logic {IDLE, RUN} state_t;
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~32'h3;
    endfunction
    function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] c, input logic en);
        return (en && c != '1) ? c + 32'd1 : c;
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read bus between the fetch stage and imem
// Signals:
//   imem_addr  - byte address driven by the fetch stage (master)
//   imem_instr - combinational read data returned by the memory (slave)
interface fetch_stage_if;
    import cpu_pkg::*;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    modport master (output imem_addr, input imem_instr);
    modport slave (input imem_addr, output imem_instr);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold, flush and load controls
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   hold_i                  - keep current contents (wins over flush/load)
//   flush_i                 - load {pc_i, BUBBLE_INSTR, valid=0}
//   load_i                  - load {pc_i, instr_i, valid=1}
//   pc_i, instr_i           - incoming PC and instruction
//   ifid_pc_o, ifid_instr_o, ifid_valid_o - registered contents
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_BUBBLE
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_instr_o,
    output logic            ifid_valid_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ifid_pc_o    <= '0;
            ifid_instr_o <= BUBBLE_INSTR;
            ifid_valid_o <= 1'b0;
        end else if (!hold_i) begin
            if (flush_i) begin
                ifid_pc_o    <= pc_i;
                ifid_instr_o <= BUBBLE_INSTR;
                ifid_valid_o <= 1'b0;
            end else if (load_i) begin
                ifid_pc_o    <= pc_i;
                ifid_instr_o <= instr_i;
                ifid_valid_o <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IDLE/RUN fetch FSM and IF/ID register with flush/stall
// Ports:
//   clk_i, rst_i     - clock, synchronous active-high reset
//   start_i          - run enable; 0 holds fetch
//   stall_i          - hazard stall (holds PC and IF/ID)
//   flush_i          - taken-branch flush, redirects PC to branch_target_i
//   branch_target_i  - redirect target, low two bits forced to 0
//   imem             - instruction-memory bus (addr = pc_o, combinational data)
//   pc_o             - current PC
//   ifid_*_o         - IF/ID register contents
//   stall_cnt_o, flush_cnt_o - saturating event counters, only with FETCH_STATS_EN
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
    parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_BUBBLE
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_instr_o,
`ifdef FETCH_STATS_EN
    output logic [XLEN-1:0] stall_cnt_o,
    output logic [XLEN-1:0] flush_cnt_o,
`endif
    output logic            ifid_valid_o
);
    state_t state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic ifid_hold, ifid_flush, ifid_load;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end
    // IDLE->RUN edge does a normal advance; leaving RUN pushes a bubble into IF/ID
    always_comb begin
        state_d    = start_i ? RUN : IDLE;
        pc_d       = pc_q;
        ifid_hold  = 1'b1;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        if (state_q == IDLE) begin
            if (start_i) begin
                pc_d      = pc_q + PC_INC;
                ifid_hold = 1'b0;
                ifid_load = 1'b1;
            end
        end else if (!start_i) begin
            ifid_hold  = 1'b0;
            ifid_flush = 1'b1;
        end else if (flush_i) begin
            pc_d       = word_align(branch_target_i);
            ifid_hold  = 1'b0;
            ifid_flush = 1'b1;
        end else if (!stall_i) begin
            pc_d      = pc_q + PC_INC;
            ifid_hold = 1'b0;
            ifid_load = 1'b1;
        end
    end
    assign pc_o           = pc_q;
    assign imem.imem_addr = pc_q;
    if_id_reg #(.BUBBLE_INSTR(BUBBLE_INSTR)) u_if_id (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .hold_i      (ifid_hold),
        .flush_i     (ifid_flush),
        .load_i      (ifid_load),
        .pc_i        (pc_q),
        .instr_i     (imem.imem_instr),
        .ifid_pc_o   (ifid_pc_o),
        .ifid_instr_o(ifid_instr_o),
        .ifid_valid_o(ifid_valid_o)
    );
`ifdef FETCH_STATS_EN
    logic run_active;
    assign run_active = (state_q == RUN) && start_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            stall_cnt_o <= sat_inc(stall_cnt_o, run_active && stall_i && !flush_i);
            flush_cnt_o <= sat_inc(flush_cnt_o, run_active && flush_i);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector scoreboard bench for fetch_stage
module tb_fetch_stage;
    import cpu_pkg::*;
    localparam logic [31:0] BUB = 32'h0000_0013;
    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] iins;
        logic        iv;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;
    logic clk = 1'b0;
    logic rst, start, stall, flush;
    logic [31:0] bt, pc, ipc, iins;
    logic iv;
`ifdef FETCH_STATS_EN
    logic [31:0] sc, fc;
`endif
    exp_t q[$];
    int total = 0;
    int bad = 0;
    int vec = 0;
    fetch_stage_if bus();
    fetch_stage #(.RESET_PC(32'h0000_0000), .BUBBLE_INSTR(BUB)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .stall_i        (stall),
        .flush_i        (flush),
        .branch_target_i(bt),
        .imem           (bus),
        .pc_o           (pc),
        .ifid_pc_o      (ipc),
        .ifid_instr_o   (iins),
`ifdef FETCH_STATS_EN
        .stall_cnt_o    (sc),
        .flush_cnt_o    (fc),
`endif
        .ifid_valid_o   (iv)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, got, want);
        end
    endtask
    task automatic step(input logic r, input logic s, input logic st, input logic fl,
                        input logic [31:0] b, input logic [31:0] ins,
                        input logic [31:0] epc, input logic [31:0] eipc, input logic [31:0] eiins,
                        input logic eiv, input logic [31:0] esc, input logic [31:0] efc);
        @(negedge clk);
        #1;
        rst = r;
        start = s;
        stall = st;
        flush = fl;
        bt = b;
        bus.imem_instr = ins;
        q.push_back('{vec, epc, eipc, eiins, eiv, esc, efc});
        vec++;
    endtask
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pc", e.idx, pc, e.pc);
                chk("imem_addr", e.idx, bus.imem_addr, e.pc);
                chk("ifid_pc", e.idx, ipc, e.ipc);
                chk("ifid_instr", e.idx, iins, e.iins);
                chk("ifid_valid", e.idx, {31'b0, iv}, {31'b0, e.iv});
`ifdef FETCH_STATS_EN
                chk("stall_cnt", e.idx, sc, e.sc);
                chk("flush_cnt", e.idx, fc, e.fc);
`endif
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
    initial begin
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        bt = '0;
        bus.imem_instr = '0;
        step(1,0,0,0,32'h0,32'h0,               32'h0,32'h0,BUB,0,0,0);
        step(1,1,1,1,32'h80,32'h11,             32'h0,32'h0,BUB,0,0,0);
        step(0,0,0,0,32'h0,32'h22,              32'h0,32'h0,BUB,0,0,0);
        step(0,0,1,1,32'h100,32'h33,            32'h0,32'h0,BUB,0,0,0);
        step(0,0,0,0,32'h0,32'h44,              32'h0,32'h0,BUB,0,0,0);
        step(0,1,0,0,32'h0,32'h0000_0093,       32'h4,32'h0,32'h0000_0093,1,0,0);
        step(0,1,0,0,32'h0,32'h0010_0113,       32'h8,32'h4,32'h0010_0113,1,0,0);
        step(0,1,0,0,32'h0,32'h0062_8233,       32'hC,32'h8,32'h0062_8233,1,0,0);
        step(0,1,1,0,32'h0,32'hDEAD_BEEF,       32'hC,32'h8,32'h0062_8233,1,1,0);
        step(0,1,1,0,32'h0,32'hDEAD_BEEF,       32'hC,32'h8,32'h0062_8233,1,2,0);
        step(0,1,0,0,32'h0,32'h0030_8193,       32'h10,32'hC,32'h0030_8193,1,2,0);
        step(0,1,1,1,32'h43,32'h0BAD_0BAD,      32'h40,32'h10,BUB,0,2,1);
        step(0,1,0,0,32'h0,32'h0040_8213,       32'h44,32'h40,32'h0040_8213,1,2,1);
        step(0,0,0,0,32'h0,32'h1111_1111,       32'h44,32'h44,BUB,0,2,1);
        step(0,0,1,1,32'h80,32'h2222_2222,      32'h44,32'h44,BUB,0,2,1);
        step(0,1,0,0,32'h0,32'h0050_8293,       32'h48,32'h44,32'h0050_8293,1,2,1);
        step(0,1,0,1,32'hFFFF_FFFF,32'h3333_3333, 32'hFFFF_FFFC,32'h48,BUB,0,2,2);
        step(0,1,0,0,32'h0,32'h0060_8313,       32'h0,32'hFFFF_FFFC,32'h0060_8313,1,2,2);
        step(0,1,0,0,32'h0,32'h0070_8393,       32'h4,32'h0,32'h0070_8393,1,2,2);
        step(1,1,0,1,32'h200,32'h4444_4444,     32'h0,32'h0,BUB,0,0,0);
        step(0,1,1,0,32'h0,32'h0080_8413,       32'h4,32'h0,32'h0080_8413,1,0,0);
        step(0,1,0,0,32'h0,32'h0090_8493,       32'h8,32'h4,32'h0090_8493,1,0,0);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter BUBBLE_INSTR, default 32'h0000_0000, instruction word written into IF/ID on flush or bubble.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 start_i  input  1  run enable; 0 holds fetch.
REQ-006 stall_i  input  1  hazard-detection stall request.
REQ-007 flush_i  input  1  taken-branch flush from ID.
REQ-008 branch_target_i  input  32  redirect PC, valid when flush_i=1.
REQ-009 imem_instr_i  input  32  combinational instruction-memory read data for imem_addr_o.
REQ-010 imem_addr_o  output  32  instruction-memory byte address, equal to pc_o.
REQ-011 pc_o  output  32  current PC register.
REQ-012 ifid_pc_o  output  32  IF/ID registered PC.
REQ-013 ifid_instr_o  output  32  IF/ID registered instruction.
REQ-014 ifid_valid_o  output  1  IF/ID holds a real instruction.

Function
REQ-015 Two states, IDLE and RUN; reset enters IDLE.
REQ-016 IDLE: PC and IF/ID hold; start_i=1 at a rising edge moves to RUN at that edge, and that edge performs a normal RUN update.
REQ-017 RUN with start_i=0 returns to IDLE; PC holds; IF/ID loads {PC, BUBBLE_INSTR, valid=0}.
REQ-018 RUN priority is flush_i over stall_i over normal advance.
REQ-019 Flush: PC<=branch_target_i; IF/ID<={PC, BUBBLE_INSTR, valid=0}.
REQ-020 Stall (flush_i=0): PC, ifid_pc_o, ifid_instr_o and ifid_valid_o all hold.
REQ-021 Normal advance: PC<=PC+4 (32-bit, wraps modulo 2^32); IF/ID<={PC, imem_instr_i, valid=1}.
REQ-022 Fetch-to-IF/ID latency is exactly one cycle; flush redirect is visible on pc_o one cycle after flush_i.
REQ-023 flush_i and stall_i are ignored in IDLE.
REQ-024 branch_target_i bits [1:0] are forced to 0 when loaded.

Reset
REQ-025 On rst_i=1 at a rising edge, regardless of state or other inputs, the block SHALL set pc_o=RESET_PC, ifid_pc_o=0, ifid_instr_o=BUBBLE_INSTR, ifid_valid_o=0, state=IDLE, and clear all counters.
REQ-026 Reset mid-RUN discards the in-flight IF/ID contents without further update.

Configuration
REQ-027 Macro FETCH_STATS_EN, when defined, adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
REQ-028 stall_cnt_o increments once per RUN cycle with stall_i=1 and flush_i=0; flush_cnt_o increments once per RUN cycle with flush_i=1; both saturate at 32'hFFFF_FFFF.
REQ-029 Without FETCH_STATS_EN, neither the counter ports nor the counter logic exist; all other behaviour is identical.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the state enum (IDLE, RUN), the XLEN=32 constant, the PC increment constant 4 and the default bubble instruction.
REQ-031 The IF/ID register is a separate sub-module, if_id_reg, with hold, flush and load controls; fetch_stage contains the PC, the FSM and the counters.

Verification
REQ-032 Reset, start_i=0 for 3 cycles -> pc_o=0, ifid_valid_o=0 throughout; start_i=1 -> pc_o sequence 4, 8, 12; ifid_pc_o lags pc_o by one cycle.
REQ-033 RUN at PC=8 with imem_instr_i=32'h0062_8233 -> next cycle ifid_instr_o=32'h0062_8233, ifid_pc_o=8, ifid_valid_o=1, pc_o=12.
REQ-034 stall_i=1 for 2 cycles at PC=12 -> pc_o and IF/ID unchanged for 2 cycles; stall_cnt_o=2; advance resumes at 16.
REQ-035 flush_i=1 and stall_i=1 together with branch_target_i=32'h0000_0043 -> pc_o=32'h40, ifid_instr_o=BUBBLE_INSTR, ifid_valid_o=0, flush_cnt_o=1, stall_cnt_o unchanged.
REQ-036 PC=32'hFFFF_FFFC, normal advance -> pc_o=0.
REQ-037 rst_i=1 during RUN with flush_i=1 -> pc_o=RESET_PC, IDLE, counters 0, ifid_valid_o=0.
